acc_bank: RTL and testbench

// - Parametrised successor to the single 8-bit accumulator: a bank of NUM_ACC accumulators.
// - Ops: load, add, subtract, clear, and multi-cycle shift.
// - Operand source is selectable: immediate, register file or ALU.
// - Ops arrive on a valid/ready handshake from the control unit. Z/C/V flags are registered.

---
 rtl/acc_pkg.sv | 22 ++
 rtl/acc_alu_core.sv | 54 +++++
 rtl/acc_bank.sv | 153 +++++++++++++++
 tb/tb_acc_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - op codes, operand-source selects and shift FSM state for the accumulator bank
package acc_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_CLR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;

  localparam logic [1:0] SRC_IMM  = 2'd0;
  localparam logic [1:0] SRC_REG  = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/acc_alu_core.sv
// rtl/acc_alu_core.sv - combinational result/flag generation for one accumulator op
// Shift ops here are a single 1-bit step; the top sequences multi-bit shifts.
module acc_alu_core
  import acc_pkg::*;
#(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] opnd_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] result_o,
  output logic         z_o,
  output logic         c_o,
  output logic         v_o
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum      = {1'b0, acc_i} + {1'b0, opnd_i};
    diff     = {1'b0, acc_i} - {1'b0, opnd_i};
    result_o = acc_i;
    c_o      = 1'b0;
    v_o      = 1'b0;
    case (op_i)
      OP_LOAD: result_o = opnd_i;
      OP_ADD: begin
        c_o      = sum[W];
        v_o      = (acc_i[W-1] == opnd_i[W-1]) && (sum[W-1] != acc_i[W-1]);
        result_o = (SAT && sum[W]) ? '1 : sum[W-1:0];
      end
      OP_SUB: begin
        c_o      = diff[W];
        v_o      = (acc_i[W-1] != opnd_i[W-1]) && (diff[W-1] != acc_i[W-1]);
        result_o = (SAT && diff[W]) ? '0 : diff[W-1:0];
      end
      OP_CLR: result_o = '0;
      OP_SHL: begin
        result_o = {acc_i[W-2:0], 1'b0};
        c_o      = acc_i[W-1];
      end
      OP_SHR: begin
        result_o = {1'b0, acc_i[W-1:1]};
        c_o      = acc_i[0];
      end
      default: ;
    endcase
    // Z always reflects what gets stored, so saturation is already folded in.
    z_o = (result_o == '0);
  end

endmodule

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - bank of NUM_ACC accumulators with registered Z/C/V flags and a multi-cycle shifter
module acc_bank
  import acc_pkg::*;
#(
  parameter int  W       = 8,
  parameter int  IMM_W   = 4,
  parameter int  NUM_ACC = 4,
  parameter int  SH_W    = 3,
  parameter bit  SAT     = 1'b0,
  localparam int AW      = $clog2(NUM_ACC)
) (
  input  logic             CLK,
  input  logic             CLB,
  input  logic [IMM_W-1:0] imm_in,
  input  logic [W-1:0]     reg_in,
  input  logic [W-1:0]     alu_in,
  input  logic [1:0]       src_sel,
  input  logic [2:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [AW-1:0]    acc_sel,
  input  logic [SH_W-1:0]  shamt,
  input  logic [AW-1:0]    rd_sel,
  output logic [W-1:0]     rd_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  state_e            state_q, state_d;
  logic [W-1:0]      acc_q [NUM_ACC];
  logic [W-1:0]      acc_d [NUM_ACC];
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     sh_sel_q, sh_sel_d;
  logic              sh_right_q, sh_right_d;
  logic              z_q, z_d, c_q, c_d, v_q, v_d;

  logic              accept, shifting, last_shift, shift_start;
  logic [W-1:0]      opnd;
  logic [AW-1:0]     core_sel;
  logic [2:0]        core_op;
  logic [W-1:0]      core_res;
  logic              core_z, core_c, core_v;

  assign accept      = op_valid && op_ready;
  assign shifting    = (state_q == SHIFT);
  assign last_shift  = shifting && (cnt_q == SH_W'(1));
  assign shift_start = accept && ((op == OP_SHL) || (op == OP_SHR)) && (shamt != '0);

  always_comb begin
    opnd = '0;
    case (src_sel)
      SRC_IMM:  opnd = {{(W-IMM_W){1'b0}}, imm_in};
      SRC_REG:  opnd = reg_in;
      SRC_ALU:  opnd = alu_in;
      default:  opnd = '0;
    endcase
  end

  // While shifting, the core is steered to the latched target and direction.
  assign core_sel = shifting ? sh_sel_q : acc_sel;
  assign core_op  = shifting ? (sh_right_q ? OP_SHR : OP_SHL) : op;

  acc_alu_core #(.W(W), .SAT(SAT)) u_core (
    .acc_i    (acc_q[core_sel]),
    .opnd_i   (opnd),
    .op_i     (core_op),
    .result_o (core_res),
    .z_o      (core_z),
    .c_o      (core_c),
    .v_o      (core_v)
  );

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shift_start) state_d = SHIFT;
      SHIFT:   if (last_shift)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state_q == IDLE);
  end

  always_comb begin
    acc_d      = acc_q;
    z_d        = z_q;
    c_d        = c_q;
    v_d        = v_q;
    cnt_d      = cnt_q;
    sh_sel_d   = sh_sel_q;
    sh_right_d = sh_right_q;
    if (shifting) begin
      acc_d[sh_sel_q] = core_res;
      c_d             = core_c;
      cnt_d           = cnt_q - SH_W'(1);
      if (last_shift) begin
        z_d = core_z;
        v_d = core_v;
      end
    end else if (accept) begin
      case (op)
        OP_LOAD, OP_ADD, OP_SUB, OP_CLR: begin
          acc_d[acc_sel] = core_res;
          z_d            = core_z;
          c_d            = core_c;
          v_d            = core_v;
        end
        OP_SHL, OP_SHR: begin
          if (shamt != '0) begin
            cnt_d      = shamt;
            sh_sel_d   = acc_sel;
            sh_right_d = (op == OP_SHR);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      cnt_q      <= '0;
      sh_sel_q   <= '0;
      sh_right_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      z_q        <= z_d;
      c_q        <= c_d;
      v_q        <= v_d;
      cnt_q      <= cnt_d;
      sh_sel_q   <= sh_sel_d;
      sh_right_q <= sh_right_d;
    end
  end

  assign rd_data = acc_q[rd_sel];
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign flag_v  = v_q;

endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - self-checking bench for acc_bank against an arithmetic reference model
module tb_acc_bank;

  logic       CLK = 1'b0;
  logic       CLB = 1'b0;
  logic [3:0] imm_in = '0;
  logic [7:0] reg_in = '0;
  logic [7:0] alu_in = '0;
  logic [1:0] src_sel = '0;
  logic [2:0] op = '0;
  logic       op_valid = 1'b0;
  logic [1:0] acc_sel = '0;
  logic [2:0] shamt = '0;
  logic [1:0] rd_sel = '0;
  logic       op_ready, flag_z, flag_c, flag_v;
  logic [7:0] rd_data;
  logic       s_ready, s_z, s_c, s_v;
  logic [7:0] s_rd;

  int n_checks = 0;
  int n_fail   = 0;

  int m_acc [4];
  bit m_z, m_c, m_v, m_busy, m_right;
  int m_left, m_tgt;
  int low;

  always #5 CLK = ~CLK;

  acc_bank #(.SAT(1'b0)) dut (
    .CLK(CLK), .CLB(CLB), .imm_in(imm_in), .reg_in(reg_in), .alu_in(alu_in),
    .src_sel(src_sel), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .acc_sel(acc_sel), .shamt(shamt), .rd_sel(rd_sel), .rd_data(rd_data),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  acc_bank #(.SAT(1'b1)) dut_sat (
    .CLK(CLK), .CLB(CLB), .imm_in(imm_in), .reg_in(reg_in), .alu_in(alu_in),
    .src_sel(src_sel), .op(op), .op_valid(op_valid), .op_ready(s_ready),
    .acc_sel(acc_sel), .shamt(shamt), .rd_sel(rd_sel), .rd_data(s_rd),
    .flag_z(s_z), .flag_c(s_c), .flag_v(s_v)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_z = 0; m_c = 0; m_v = 0; m_busy = 0; m_right = 0; m_left = 0; m_tgt = 0;
  endtask

  function automatic int to_signed(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference behaviour for one rising edge, from the inputs present at that edge.
  task automatic model_step();
    int a, b, r, t;
    if (m_busy) begin
      a = m_acc[m_tgt];
      if (m_right) begin m_c = (a % 2) == 1; r = a / 2; end
      else         begin m_c = (a >= 128);  r = (a * 2) % 256; end
      m_acc[m_tgt] = r;
      m_left--;
      if (m_left == 0) begin m_busy = 0; m_z = (r == 0); m_v = 0; end
    end else if (op_valid) begin
      a = m_acc[acc_sel];
      case (src_sel)
        2'd0: b = int'(imm_in);
        2'd1: b = int'(reg_in);
        2'd2: b = int'(alu_in);
        default: b = 0;
      endcase
      case (op)
        3'd1: begin m_acc[acc_sel] = b; m_z = (b == 0); m_c = 0; m_v = 0; end
        3'd2: begin
          t = a + b; m_c = (t > 255); r = t % 256;
          t = to_signed(a) + to_signed(b); m_v = (t > 127) || (t < -128);
          m_acc[acc_sel] = r; m_z = (r == 0);
        end
        3'd3: begin
          m_c = (a < b); r = (a - b + 256) % 256;
          t = to_signed(a) - to_signed(b); m_v = (t > 127) || (t < -128);
          m_acc[acc_sel] = r; m_z = (r == 0);
        end
        3'd4: begin m_acc[acc_sel] = 0; m_z = 1; m_c = 0; m_v = 0; end
        3'd5, 3'd6: if (shamt != 0) begin
          m_busy = 1; m_left = int'(shamt); m_tgt = int'(acc_sel); m_right = (op == 3'd6);
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("op_ready", int'(op_ready), int'(!m_busy));
    chk("rd_data",  int'(rd_data),  m_acc[rd_sel]);
    chk("flag_z",   int'(flag_z),   int'(m_z));
    chk("flag_c",   int'(flag_c),   int'(m_c));
    chk("flag_v",   int'(flag_v),   int'(m_v));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
  endtask

  task automatic set_op(input int o, input int s, input int a, input int val, input int sh);
    op_valid = 1'b1;
    op       = 3'(o);
    src_sel  = 2'(s);
    acc_sel  = 2'(a);
    shamt    = 3'(sh);
    imm_in   = (s == 0) ? 4'(val) : 4'($urandom);
    reg_in   = (s == 1) ? 8'(val) : 8'($urandom);
    alu_in   = (s == 2) ? 8'(val) : 8'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    compare();
    chk("rst_ready", int'(op_ready), 1);
    CLB = 1'b1;

    set_op(1, 0, 1, 'hA, 0); rd_sel = 2'd1; cycle(); op_valid = 1'b0;
    chk("load_imm", int'(rd_data), 'h0A);
    chk("load_imm_z", int'(flag_z), 0);
    chk("model_load", m_acc[1], 'h0A);

    set_op(1, 1, 0, 'hFF, 0); rd_sel = 2'd0; cycle();
    set_op(2, 0, 0, 1, 0); cycle(); op_valid = 1'b0;
    chk("add_wrap", int'(rd_data), 'h00);
    chk("add_wrap_z", int'(flag_z), 1);
    chk("add_wrap_c", int'(flag_c), 1);
    chk("add_wrap_v", int'(flag_v), 0);
    chk("sat_add", int'(s_rd), 'hFF);
    chk("sat_add_c", int'(s_c), 1);
    chk("sat_add_z", int'(s_z), 0);

    set_op(1, 1, 3, 'h7F, 0); rd_sel = 2'd3; cycle();
    set_op(2, 2, 3, 1, 0); cycle(); op_valid = 1'b0;
    chk("add_ovf", int'(rd_data), 'h80);
    chk("add_ovf_v", int'(flag_v), 1);
    chk("add_ovf_c", int'(flag_c), 0);
    chk("model_ovf_v", int'(m_v), 1);

    set_op(1, 1, 3, 'h03, 0); cycle();
    set_op(3, 1, 3, 'h05, 0); cycle(); op_valid = 1'b0;
    chk("sub_borrow", int'(rd_data), 'hFE);
    chk("sub_borrow_c", int'(flag_c), 1);
    chk("sat_sub", int'(s_rd), 'h00);
    chk("sat_sub_c", int'(s_c), 1);
    chk("sat_sub_z", int'(s_z), 1);

    set_op(1, 1, 2, 'h81, 0); rd_sel = 2'd2; cycle();
    set_op(5, 3, 2, 0, 3); cycle();
    set_op(1, 0, 1, 5, 0);
    low = 0;
    for (int k = 0; k < 20; k++) begin
      if (op_ready) break;
      low++;
      cycle();
    end
    chk("shl_busy_cycles", low, 3);
    chk("shl_result", int'(rd_data), 'h08);
    chk("shl_c", int'(flag_c), 0);
    rd_sel = 2'd1; #1;
    chk("held_not_early", int'(rd_data), 'h0A);
    cycle(); op_valid = 1'b0;
    chk("held_load", int'(rd_data), 'h05);

    set_op(1, 1, 0, 'hB6, 0); rd_sel = 2'd0; cycle();
    set_op(6, 3, 0, 0, 5); cycle(); op_valid = 1'b0;
    cycle(); cycle();
    chk("shr_mid", int'(rd_data), 'h2D);
    CLB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      chk("rst_mid_rd", int'(rd_data), 0);
    end
    chk("rst_mid_z", int'(flag_z), 0);
    chk("rst_mid_c", int'(flag_c), 0);
    chk("rst_mid_v", int'(flag_v), 0);
    chk("rst_mid_ready", int'(op_ready), 1);
    model_reset();
    @(negedge CLK);
    CLB = 1'b1;
    compare();

    set_op(1, 1, 2, 'h3C, 0); rd_sel = 2'd2; cycle(); op_valid = 1'b0;
    chk("load_after_rst", int'(rd_data), 'h3C);

    for (int n = 0; n < 3000; n++) begin
      op_valid = ($urandom_range(0, 3) != 0);
      op       = 3'($urandom);
      src_sel  = 2'($urandom);
      imm_in   = 4'($urandom);
      reg_in   = 8'($urandom);
      alu_in   = 8'($urandom);
      acc_sel  = 2'($urandom);
      shamt    = 3'($urandom);
      rd_sel   = 2'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
